// File: rtl/c1_mem_responder.sv
// C1 bus responder: decodes CPU commands, serves a small line store, answers with WRITE32_RESP.
// Optional build macro: C1_INV_ZERO_EN (INV_LINE clears the addressed line).
module c1_mem_responder #(
   parameter int MEM_ADDR_SIZE     = 19,
   parameter int BUS_SIZE          = 16,
   parameter int CACHE_OFFSET_SIZE = 4,
   parameter int STORE_LINES       = 64,
   parameter int RESP_DELAY        = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
   inout  wire  [BUS_SIZE-1:0]                       data,
   inout  wire  [2:0]                                command,
   output logic                                      busy
);

   localparam int AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
   localparam int OW = CACHE_OFFSET_SIZE;
   localparam int LB = 2 ** CACHE_OFFSET_SIZE;
   localparam int IW = $clog2(STORE_LINES);
   localparam int CW = $clog2(RESP_DELAY + 2);

   localparam logic [2:0] C_READ8   = 3'd1;
   localparam logic [2:0] C_READ16  = 3'd2;
   localparam logic [2:0] C_READ32  = 3'd3;
   localparam logic [2:0] C_WRITE8  = 3'd5;
   localparam logic [2:0] C_WRITE16 = 3'd6;
   localparam logic [2:0] C_RESP    = 3'd7;
`ifdef C1_INV_ZERO_EN
   localparam logic [2:0] C_INV     = 3'd4;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR2, S_TURN, S_WAIT, S_RESP1, S_RESP2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [2:0]            r_cmd;
   logic [IW-1:0]         r_idx;
   logic [OW-1:0]         r_off;
   logic [BUS_SIZE-1:0]   r_w0;
   logic [CW-1:0]         r_cnt;
   logic [OW-1:0]         w_off_al;
   logic [OW-1:0]         w_o1;
   logic [OW-1:0]         w_o2;
   logic [OW-1:0]         w_o3;
   logic                  w_cmd_ok;
   logic                  w_is_wr;
   logic                  w_drv;
   logic [BUS_SIZE-1:0]   w_rdata;
   logic                  w_unused_addr;

   logic [7:0] r_mem [STORE_LINES][LB] = '{default: '0};

   assign w_cmd_ok      = (command >= 3'd1) && (command <= 3'd6);
   assign w_is_wr       = (command == C_WRITE8) || (command == C_WRITE16);
   assign w_o1          = {r_off[OW-1:1], 1'b1};
   assign w_o2          = {r_off[OW-1:2], 2'b10};
   assign w_o3          = {r_off[OW-1:2], 2'b11};
   assign w_unused_addr = ^address[AW-1:IW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_cmd_ok) w_next = S_ADDR2;
         S_ADDR2: w_next = S_TURN;
         S_TURN:  w_next = (RESP_DELAY == 0) ? S_RESP1 : S_WAIT;
         S_WAIT:  if (r_cnt == CW'(1)) w_next = S_RESP1;
         S_RESP1: w_next = (r_cmd == C_READ32) ? S_RESP2 : S_IDLE;
         S_RESP2: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Misaligned offsets are silently rounded down to the access size
   always_comb begin
      w_off_al = address[OW-1:0];
      unique case (1'b1)
         (r_cmd == C_READ16) || (r_cmd == C_WRITE16): w_off_al[0]   = 1'b0;
         (r_cmd == C_READ32):                         w_off_al[1:0] = 2'b00;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd <= '0;
         r_idx <= '0;
         r_off <= '0;
         r_w0  <= '0;
         r_cnt <= '0;
      end else begin
         if (r_state == S_IDLE && w_cmd_ok) begin
            r_cmd <= command;
            r_idx <= address[IW-1:0];
            r_w0  <= w_is_wr ? data : '0;
         end
         if (r_state == S_ADDR2) r_off <= w_off_al;
         if (r_state == S_TURN)      r_cnt <= CW'(RESP_DELAY);
         else if (r_state == S_WAIT) r_cnt <= r_cnt - CW'(1);
      end
   end

   // Store commits at the edge leaving RESP1; reset forces IDLE so aborts never write
   always_ff @(posedge clk) begin
      if (r_state == S_RESP1) begin
         unique case (r_cmd)
            C_WRITE8: r_mem[r_idx][r_off] <= r_w0[7:0];
            C_WRITE16: begin
               r_mem[r_idx][r_off] <= r_w0[7:0];
               r_mem[r_idx][w_o1]  <= r_w0[15:8];
            end
`ifdef C1_INV_ZERO_EN
            C_INV: begin
               for (int i = 0; i < LB; i++) r_mem[r_idx][OW'(i)] <= '0;
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      w_drv   = 1'b0;
      w_rdata = '0;
      busy    = 1'b0;
      unique case (r_state)
         S_ADDR2, S_TURN, S_WAIT: busy = 1'b1;
         S_RESP1: begin
            busy  = 1'b1;
            w_drv = 1'b1;
            unique case (r_cmd)
               C_READ8:  w_rdata = BUS_SIZE'(r_mem[r_idx][r_off]);
               C_READ16,
               C_READ32: w_rdata = BUS_SIZE'({r_mem[r_idx][w_o1], r_mem[r_idx][r_off]});
               default:  w_rdata = '0;
            endcase
         end
         S_RESP2: begin
            busy    = 1'b1;
            w_drv   = 1'b1;
            w_rdata = BUS_SIZE'({r_mem[r_idx][w_o3], r_mem[r_idx][w_o2]});
         end
         default: ;
      endcase
   end

   assign data    = w_drv ? w_rdata : 'z;
   assign command = w_drv ? C_RESP  : 'z;

endmodule

// File: tb/tb_c1_mem_responder.sv
// Directed bench for c1_mem_responder: two instances (RESP_DELAY 4 and 0) on mirrored buses.
module tb_c1_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tb_en;
   logic [2:0]  tb_cmd;
   logic [14:0] tb_addr;
   logic [15:0] tb_data;
   wire  [15:0] data_a;
   wire  [15:0] data_b;
   wire  [2:0]  cmd_a;
   wire  [2:0]  cmd_b;
   logic        busy_a;
   logic        busy_b;

   int n_err = 0;
   int n_chk = 0;
   int f7a, n7a, nba, f7b, n7b, nbb;
   logic [15:0] r0, r1;
   logic        end_a;

   always #5 clk = ~clk;

   assign data_a = tb_en ? tb_data : 'z;
   assign cmd_a  = tb_en ? tb_cmd  : 'z;
   assign data_b = tb_en ? tb_data : 'z;
   assign cmd_b  = tb_en ? tb_cmd  : 'z;

   c1_mem_responder #(.RESP_DELAY(4)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .address (tb_addr),
      .data    (data_a),
      .command (cmd_a),
      .busy    (busy_a)
   );

   c1_mem_responder #(.RESP_DELAY(0)) u_dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .address (tb_addr),
      .data    (data_b),
      .command (cmd_b),
      .busy    (busy_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Phase 1 at negedge 0, phase 2 at negedge 1, release at negedge 2; observe 20 negedges
   task automatic xact(input logic [2:0] c, input logic [14:0] line,
                       input logic [3:0] off, input logic [15:0] wd);
      f7a = 0; n7a = 0; nba = 0; f7b = 0; n7b = 0; nbb = 0;
      r0 = '0; r1 = '0; end_a = 1'b0;
      @(negedge clk);
      tb_en = 1'b1; tb_cmd = c; tb_addr = line; tb_data = wd;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (cmd_a == 3'd7) begin
            if (n7a == 0) begin f7a = k; r0 = data_a; end
            else r1 = data_a;
            n7a++;
         end
         if (busy_a) nba++;
         if (cmd_b == 3'd7) begin
            if (n7b == 0) f7b = k;
            n7b++;
         end
         if (busy_b) nbb++;
         if (k == 20) end_a = (cmd_a == 3'd7) || busy_a;
         if (k == 1) begin tb_cmd = 3'd0; tb_addr = {11'd0, off}; end
         if (k == 2) tb_en = 1'b0;
      end
   endtask

   initial begin
      int cnt;
      tb_en = 1'b0; tb_cmd = '0; tb_addr = '0; tb_data = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy_a", busy_a, 0);
      check("rst_busy_b", busy_b, 0);
      check("rst_cmd_a", cmd_a == 3'd7, 0);
      rst_n = 1'b1;
      @(negedge clk);

      xact(3'd6, 15'h0003, 4'h4, 16'hBEEF);
      check("w16_n7", n7a, 1);
      check("w16_data", r0, 16'h0000);
      check("w16_lat", f7a, 7);
      xact(3'd6, 15'h0003, 4'h6, 16'hDEAD);

      xact(3'd3, 15'h0003, 4'h4, 16'h0);
      check("r32_w0", r0, 16'hBEEF);
      check("r32_w1", r1, 16'hDEAD);
      check("r32_n7", n7a, 2);
      check("r32_busy_a", nba, 8);
      check("r32_busy_b", nbb, 4);
      check("r32_n7_b", n7b, 2);
      check("r32_release", end_a, 0);
      xact(3'd3, 15'h0003, 4'h6, 16'h0);
      check("r32_mis_w0", r0, 16'hBEEF);
      check("r32_mis_w1", r1, 16'hDEAD);

      xact(3'd5, 15'h0007, 4'h2, 16'h00A5);
      xact(3'd2, 15'h0007, 4'h3, 16'h0);
      check("r16_lo", r0[7:0], 8'hA5);
      xact(3'd1, 15'h0007, 4'h2, 16'h0);
      check("r8_data", r0, 16'h00A5);
      check("r8_lat_a", f7a, 7);
      check("r8_lat_b", f7b, 3);
      check("r8_busy_a", nba, 7);
      check("r8_busy_b", nbb, 3);
      check("r8_n7", n7a, 1);
      xact(3'd1, 15'h0007, 4'h3, 16'h0);
      check("r8_zero", r0, 16'h0000);
      xact(3'd5, 15'h0007, 4'h3, 16'h12C3);
      xact(3'd2, 15'h0007, 4'h2, 16'h0);
      check("w8_merge", r0, 16'hC3A5);

      xact(3'd6, 15'h0001, 4'h8, 16'h1234);
      xact(3'd2, 15'h0041, 4'h9, 16'h0);
      check("alias", r0, 16'h1234);

      xact(3'd4, 15'h0003, 4'h0, 16'h0);
      check("inv_data", r0, 16'h0000);
      check("inv_n7", n7a, 1);
      xact(3'd3, 15'h0003, 4'h4, 16'h0);
`ifdef C1_INV_ZERO_EN
      check("inv_w0", r0, 16'h0000);
      check("inv_w1", r1, 16'h0000);
`else
      check("inv_w0", r0, 16'hBEEF);
      check("inv_w1", r1, 16'hDEAD);
`endif

      @(negedge clk);
      tb_en = 1'b1; tb_cmd = 3'd7; tb_addr = 15'h0003;
      @(negedge clk);
      tb_en = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (busy_a || busy_b) cnt++;
      end
      check("cmd7_ignored", cnt, 0);

      xact(3'd6, 15'h0009, 4'h0, 16'h1111);
      xact(3'd2, 15'h0009, 4'h0, 16'h0);
      check("pre_rst", r0, 16'h1111);
      @(negedge clk);
      tb_en = 1'b1; tb_cmd = 3'd6; tb_addr = 15'h0009; tb_data = 16'h5555;
      @(negedge clk);
      tb_cmd = 3'd0; tb_addr = 15'h0000;
      @(negedge clk);
      tb_en = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_abort_busy", busy_a, 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy_a, 0);
      check("abort_cmd", cmd_a == 3'd7, 0);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 2) rst_n = 1'b1;
         if (cmd_a == 3'd7 || busy_a) cnt++;
      end
      check("abort_quiet", cnt, 0);
      xact(3'd2, 15'h0009, 4'h0, 16'h0);
      check("abort_keep", r0, 16'h1111);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
